stream_mux_arb: RTL and testbench

//  Parametrised N:1 streaming mux: generalises the 8-bit 2:1 mux to NUM_CH channels of DATA_W bits.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/stream_mux_arb_rr_arbiter.sv | 38 +++
 rtl/stream_mux_arb.sv | 68 ++++++
 tb/tb_stream_mux_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and helpers for the N:1 stream mux
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    // Channel-index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rtl/stream_mux_arb_rr_arbiter.sv - round-robin arbiter holding its own last-grant pointer
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int SEL_W = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    logic [SEL_W-1:0] rr_ptr;

    // Scan downward so the channel nearest rr_ptr+1 is written last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req[(int'(rr_ptr) + i) % NUM_CH]) begin
                gnt_idx = SEL_W'((int'(rr_ptr) + i) % NUM_CH);
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= SEL_W'(NUM_CH - 1);
        end else if (adv) begin
            rr_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N:1 stream mux with select or round-robin grant and a registered output
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int        NUM_CH = 4,
    parameter int        DATA_W = 8,
    parameter mux_mode_e MODE   = MODE_SEL,
    localparam int       SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [NUM_CH-1:0]        in_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic [NUM_CH-1:0]        in_ready_o,
    output logic                     out_valid_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [SEL_W-1:0]         out_ch_o,
    input  logic                     out_ready_i
);

    logic             load_en;
    logic             gnt_vld;
    logic             xfer;
    logic [SEL_W-1:0] gnt_idx;

    assign load_en = !out_valid_o || out_ready_i;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic sel_unused;
            assign sel_unused = ^sel_i;

            rr_arbiter #(
                .NUM_CH (NUM_CH)
            ) u_arb (
                .clk     (clk),
                .reset   (reset),
                .req     (in_valid_i),
                .adv     (xfer),
                .gnt_idx (gnt_idx),
                .gnt_vld (gnt_vld)
            );
        end else begin : g_sel
            assign gnt_idx = sel_i;
            assign gnt_vld = (int'(sel_i) < NUM_CH) && in_valid_i[sel_i];
        end
    endgenerate

    // gnt_vld already implies the granted channel is valid, so ready doubles as the transfer strobe.
    assign xfer       = !reset && gnt_vld && load_en;
    assign in_ready_o = xfer ? (NUM_CH'(1) << gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
        end else if (xfer) begin
            out_valid_o <= 1'b1;
            out_data_o  <= in_data_i[gnt_idx*DATA_W +: DATA_W];
            out_ch_o    <= gnt_idx;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - self-checking bench for stream_mux_arb in both selection modes
module tb_stream_mux_arb;
    import stream_mux_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  s_sel, r_sel;
    logic [3:0]  s_vld, r_vld, s_rdy, r_rdy;
    logic [31:0] s_dat, r_dat;
    logic        s_ovld, r_ovld, s_ordy, r_ordy;
    logic [7:0]  s_odat, r_odat;
    logic [1:0]  s_och, r_och;

    stream_mux_arb #(.NUM_CH(4), .DATA_W(8), .MODE(MODE_SEL)) u_sel (
        .clk(clk), .reset(reset), .sel_i(s_sel), .in_valid_i(s_vld), .in_data_i(s_dat),
        .in_ready_o(s_rdy), .out_valid_o(s_ovld), .out_data_o(s_odat), .out_ch_o(s_och),
        .out_ready_i(s_ordy)
    );

    stream_mux_arb #(.NUM_CH(4), .DATA_W(8), .MODE(MODE_RR)) u_rr (
        .clk(clk), .reset(reset), .sel_i(r_sel), .in_valid_i(r_vld), .in_data_i(r_dat),
        .in_ready_o(r_rdy), .out_valid_o(r_ovld), .out_data_o(r_odat), .out_ch_o(r_och),
        .out_ready_i(r_ordy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference state: what the output register must hold, and the last RR winner.
    bit         m_init = 1'b0;
    logic       m_v[2];
    logic [7:0] m_d[2];
    int         m_c[2];
    int         m_p[2];
    logic [3:0] acc[2];
    bit         sb_on = 1'b0;
    int         seq[2][4];
    int         dlv[2][4];

    task automatic model(input int d, input bit rr, input logic [3:0] vld, input logic [31:0] dat,
                         input logic [1:0] sel, input logic ordy, input logic [3:0] rdy,
                         input logic ovld, input logic [7:0] odat, input logic [1:0] och);
        int g = 0;
        bit gv = 1'b0;
        bit load;
        logic [3:0] er;
        load = !m_v[d] || ordy;
        if (!rr) begin
            g  = int'(sel);
            gv = vld[sel];
        end else begin
            for (int i = 1; i <= 4; i++) begin
                if (!gv && vld[(m_p[d] + i) % 4]) begin
                    g  = (m_p[d] + i) % 4;
                    gv = 1'b1;
                end
            end
        end
        er = (!reset && gv && load) ? 4'(1 << g) : 4'd0;
        if (m_init) begin
            chk($sformatf("d%0d in_ready", d), 32'(rdy), 32'(er));
            chk($sformatf("d%0d out_valid", d), 32'(ovld), 32'(m_v[d]));
            chk($sformatf("d%0d out_data", d), 32'(odat), 32'(m_d[d]));
            chk($sformatf("d%0d out_ch", d), 32'(och), 32'(m_c[d]));
        end
        acc[d] = rdy & vld;
        if (sb_on && ovld && ordy) begin
            chk($sformatf("d%0d sb_order", d), 32'(odat), 32'({och, 6'(dlv[d][och])}));
            dlv[d][och]++;
        end
        if (reset) begin
            m_v[d] = 1'b0; m_d[d] = 8'h00; m_c[d] = 0; m_p[d] = 3;
        end else if (er != 4'd0) begin
            m_v[d] = 1'b1; m_d[d] = dat[g*8 +: 8]; m_c[d] = g; m_p[d] = g;
        end else if (ordy) begin
            m_v[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        model(0, 1'b0, s_vld, s_dat, s_sel, s_ordy, s_rdy, s_ovld, s_odat, s_och);
        model(1, 1'b1, r_vld, r_dat, r_sel, r_ordy, r_rdy, r_ovld, r_odat, r_och);
        if (reset) m_init = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Producer: hold valid/data until accepted, then present the next numbered beat.
    task automatic prod(input int d, inout logic [3:0] v, inout logic [31:0] dt);
        for (int k = 0; k < 4; k++) begin
            if (acc[d][k]) seq[d][k]++;
            if (acc[d][k] || !v[k]) v[k] = ($urandom_range(0, 9) < 6);
            dt[k*8 +: 8] = {2'(k), 6'(seq[d][k])};
        end
    endtask

    int fair[9] = '{1, 2, 3, 0, 1, 3, 1, 3, 1};

    initial begin
        reset = 1'b1;
        s_vld = 4'hF; r_vld = 4'hF;
        s_dat = 32'hDDCCBBAA; r_dat = 32'hDDCCBBAA;
        s_sel = 2'd2; r_sel = 2'd0;
        s_ordy = 1'b1; r_ordy = 1'b1;
        step(); step();
        #1;
        chk("rst r out_valid", 32'(r_ovld), 32'h0);
        chk("rst r out_data", 32'(r_odat), 32'h00);
        chk("rst r in_ready", 32'(r_rdy), 32'h0);
        chk("rst s in_ready", 32'(s_rdy), 32'h0);
        reset = 1'b0;
        #1;
        chk("rr first grant", 32'(r_rdy), 32'b0001);
        chk("sel ready", 32'(s_rdy), 32'b0100);
        step();
        chk("rr first ch", 32'(r_och), 32'd0);
        chk("rr first data", 32'(r_odat), 32'hAA);
        chk("sel data", 32'(s_odat), 32'hCC);
        chk("sel ch", 32'(s_och), 32'd2);

        for (int i = 0; i < 9; i++) begin
            if (i == 5) r_vld = 4'b1010;
            step();
            chk($sformatf("rr fair %0d", i), 32'(r_och), 32'(fair[i]));
        end

        s_ordy = 1'b0;
        s_sel  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall s ready", 32'(s_rdy), 32'h0);
            chk("stall s data", 32'(s_odat), 32'hCC);
            chk("stall s ch", 32'(s_och), 32'd2);
            step();
        end
        s_ordy = 1'b1;
        #1;
        chk("unstall s ready", 32'(s_rdy), 32'b0010);
        step();
        chk("unstall s data", 32'(s_odat), 32'hBB);
        chk("unstall s ch", 32'(s_och), 32'd1);

        r_vld = 4'hF;
        step();
        chk("rr to ch2", 32'(r_och), 32'd2);
        r_ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr stall ready", 32'(r_rdy), 32'h0);
            chk("rr stall ch", 32'(r_och), 32'd2);
            step();
        end
        r_ordy = 1'b1;
        #1;
        chk("rr after stall", 32'(r_rdy), 32'b1000);
        step();
        chk("rr ch3", 32'(r_och), 32'd3);
        chk("rr ch3 data", 32'(r_odat), 32'hDD);

        s_sel = 2'd0;
        s_dat[7:0] = 8'h5A;
        step();
        chk("hold 5A", 32'(s_odat), 32'h5A);
        s_ordy = 1'b0;
        step();
        chk("stall 5A", 32'(s_odat), 32'h5A);
        reset = 1'b1;
        step();
        chk("rst drop valid", 32'(s_ovld), 32'h0);
        chk("rst drop data", 32'(s_odat), 32'h00);
        reset = 1'b0;
        s_vld = 4'h0; r_vld = 4'h0;
        s_ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("5A never sent", 32'(s_ovld), 32'h0);
        end

        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                seq[d][k] = 0;
                dlv[d][k] = 0;
            end
        acc[0] = 4'h0; acc[1] = 4'h0;
        prod(0, s_vld, s_dat);
        prod(1, r_vld, r_dat);
        sb_on = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            step();
            prod(0, s_vld, s_dat);
            prod(1, r_vld, r_dat);
            s_sel  = 2'($urandom_range(0, 3));
            r_sel  = 2'($urandom_range(0, 3));
            s_ordy = ($urandom_range(0, 9) < 7);
            r_ordy = ($urandom_range(0, 9) < 7);
        end
        step();
        prod(0, s_vld, s_dat);
        prod(1, r_vld, r_dat);
        s_vld = 4'h0; r_vld = 4'h0;
        s_ordy = 1'b1; r_ordy = 1'b1;
        repeat (3) step();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("d%0d ch%0d count", d, k), 32'(dlv[d][k]), 32'(seq[d][k]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
